// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic-light command path: command and error codes,
// the byte-parser state encoding and the default frame header.
package traffic_lights_pkg;

   typedef enum logic [2:0] {
      CMD_ON            = 3'd0,
      CMD_OFF           = 3'd1,
      CMD_UNMANAGED     = 3'd2,
      CMD_SET_GREEN_MS  = 3'd3,
      CMD_SET_RED_MS    = 3'd4,
      CMD_SET_YELLOW_MS = 3'd5
   } cmd_type_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TYPE    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_TYPE    = 3'd1,
      ST_DATA_HI = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_CSUM    = 3'd4,
      ST_ISSUE   = 3'd5
   } parser_state_t;

   localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
   localparam logic [2:0] CMD_TYPE_MAX        = 3'd5;

endpackage

// File: rtl/traffic_lights_cmd_timeout.sv
// Inter-byte idle counter: expired_o flags the cycle in which the count of
// idle cycles since the last clear would reach TIMEOUT_TICKS.
module traffic_lights_cmd_timeout #(
   parameter int unsigned TIMEOUT_TICKS = 200
) (
   input  logic clk_i,
   input  logic arst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [15:0] LAST_TICK = 16'(TIMEOUT_TICKS - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LAST_TICK);

endmodule

// File: rtl/traffic_lights_cmd_parser.sv
// Assembles header/type/data_hi/data_lo/checksum byte frames into one-cycle
// commands for the traffic-light controller; bad or stale frames raise err_o.
module traffic_lights_cmd_parser
   import traffic_lights_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 200,
   parameter logic [7:0]  HEADER_BYTE   = HEADER_BYTE_DEFAULT
) (
   input  logic        clk_0m002,
   input  logic        arst_n_i,
   input  logic [7:0]  byte_data_i,
   input  logic        byte_val_i,
   output logic        byte_rdy_o,
   output logic [2:0]  cmd_type_o,
   output logic [15:0] cmd_data_o,
   output logic        cmd_val_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [7:0]  err_cnt_o,
   output logic [15:0] frame_cnt_o
);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   parser_state_t state_q, state_d;
   cmd_type_t     type_q, type_d;
   logic [7:0]    hi_q, hi_d, lo_q, lo_d;
   cmd_type_t     cmd_type_q, cmd_type_d;
   logic [15:0]   cmd_data_q, cmd_data_d;
   logic          cmd_val_q, cmd_val_d;
   logic          err_q, err_d;
   err_code_t     err_code_q, err_code_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   logic          byte_acc, in_frame, tmo_expired, err_hit;
   err_code_t     err_hit_code;
   logic [7:0]    csum_exp;

   assign byte_rdy_o = (state_q != ST_ISSUE);
   assign byte_acc   = byte_val_i && byte_rdy_o;
   assign in_frame   = (state_q == ST_TYPE) || (state_q == ST_DATA_HI) ||
                       (state_q == ST_DATA_LO) || (state_q == ST_CSUM);
   assign csum_exp   = {5'd0, type_q} ^ hi_q ^ lo_q;

   traffic_lights_cmd_timeout #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) u_timeout (
      .clk_i    (clk_0m002),
      .arst_n_i (arst_n_i),
      .clr_i    (byte_acc || !in_frame || tmo_expired),
      .en_i     (in_frame),
      .expired_o(tmo_expired)
   );

   always_comb begin
      state_d      = state_q;
      type_d       = type_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      cmd_type_d   = cmd_type_q;
      cmd_data_d   = cmd_data_q;
      cmd_val_d    = 1'b0;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      err_cnt_d    = err_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      err_hit      = 1'b0;
      err_hit_code = ERR_NONE;

      // An accepted byte takes priority over a timeout landing in the same cycle.
      if (in_frame && !byte_acc && tmo_expired) begin
         err_hit      = 1'b1;
         err_hit_code = ERR_TIMEOUT;
         state_d      = ST_HUNT;
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (byte_acc && byte_data_i == HEADER_BYTE) state_d = ST_TYPE;
            end
            ST_TYPE: begin
               if (byte_acc) begin
                  if (byte_data_i[7:3] == 5'd0 && byte_data_i[2:0] <= CMD_TYPE_MAX) begin
                     type_d  = cmd_type_t'(byte_data_i[2:0]);
                     state_d = ST_DATA_HI;
                  end else begin
                     err_hit      = 1'b1;
                     err_hit_code = ERR_TYPE;
                     state_d      = ST_HUNT;
                  end
               end
            end
            ST_DATA_HI: begin
               if (byte_acc) begin
                  hi_d    = byte_data_i;
                  state_d = ST_DATA_LO;
               end
            end
            ST_DATA_LO: begin
               if (byte_acc) begin
                  lo_d    = byte_data_i;
                  state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (byte_acc) begin
                  if (byte_data_i == csum_exp) begin
                     cmd_val_d   = 1'b1;
                     cmd_type_d  = type_q;
                     cmd_data_d  = {hi_q, lo_q};
                     frame_cnt_d = frame_cnt_q + 16'd1;
                     state_d     = ST_ISSUE;
                  end else begin
                     err_hit      = 1'b1;
                     err_hit_code = ERR_CSUM;
                     state_d      = ST_HUNT;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end

      if (err_hit) begin
         err_d      = 1'b1;
         err_code_d = err_hit_code;
         err_cnt_d  = sat_inc8(err_cnt_q);
      end
   end

   always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q     <= ST_HUNT;
         type_q      <= CMD_ON;
         hi_q        <= '0;
         lo_q        <= '0;
         cmd_type_q  <= CMD_ON;
         cmd_data_q  <= '0;
         cmd_val_q   <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_cnt_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cmd_type_q  <= cmd_type_d;
         cmd_data_q  <= cmd_data_d;
         cmd_val_q   <= cmd_val_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         err_cnt_q   <= err_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cmd_type_o  = cmd_type_q;
   assign cmd_data_o  = cmd_data_q;
   assign cmd_val_o   = cmd_val_q;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;
   assign err_cnt_o   = err_cnt_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_traffic_lights_cmd_parser.sv
// Scoreboard bench for traffic_lights_cmd_parser: a frame-level reference model
// predicts command/error events; a negedge monitor pops and compares them.
module tb_traffic_lights_cmd_parser;

   localparam int T = 20;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_val = 1'b0;
   logic        byte_rdy;
   logic [2:0]  cmd_type;
   logic [15:0] cmd_data;
   logic        cmd_val;
   logic        err_o;
   logic [1:0]  err_code;
   logic [7:0]  err_cnt;
   logic [15:0] frame_cnt;

   traffic_lights_cmd_parser #(.TIMEOUT_TICKS(T), .HEADER_BYTE(8'hA5)) dut (
      .clk_0m002  (clk),
      .arst_n_i   (arst_n),
      .byte_data_i(byte_data),
      .byte_val_i (byte_val),
      .byte_rdy_o (byte_rdy),
      .cmd_type_o (cmd_type),
      .cmd_data_o (cmd_data),
      .cmd_val_o  (cmd_val),
      .err_o      (err_o),
      .err_code_o (err_code),
      .err_cnt_o  (err_cnt),
      .frame_cnt_o(frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      bit          is_cmd;
      int          cyc;
      logic [2:0]  typ;
      logic [15:0] data;
      logic [1:0]  code;
      logic [7:0]  ecnt;
      logic [15:0] fcnt;
   } ev_t;
   ev_t expq[$];

   // Reference model state: position within a frame, captured bytes, counters.
   int         m_pos;
   logic [7:0] m_fr[0:2];
   int         m_last;
   int         m_issue;
   int         m_ecnt;
   int         m_fcnt;
   logic [2:0] m_typ;
   logic [15:0] m_data;
   logic [1:0] m_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_cmd, input int at);
      ev_t e;
      e.is_cmd = is_cmd;
      e.cyc    = at;
      e.typ    = m_typ;
      e.data   = m_data;
      e.code   = m_code;
      e.ecnt   = 8'(m_ecnt);
      e.fcnt   = 16'(m_fcnt);
      expq.push_back(e);
   endtask

   task automatic m_reset();
      m_pos = 0; m_last = 0; m_issue = -1; m_ecnt = 0; m_fcnt = 0;
      m_typ = 3'd0; m_data = 16'd0; m_code = 2'd0;
   endtask

   task automatic m_error(input logic [1:0] code, input int at);
      m_code = code;
      if (m_ecnt < 255) m_ecnt++;
      m_pos = 0;
      push_ev(1'b0, at);
   endtask

   // A frame left idle for T full cycles is dropped T cycles after its last byte.
   task automatic m_expire(input int te);
      if (m_pos != 0 && (te - m_last - 1) >= T) m_error(2'd3, m_last + T);
   endtask

   task automatic m_accept(input logic [7:0] b, input int te);
      m_last = te;
      case (m_pos)
         0: if (b == 8'hA5) m_pos = 1;
         1: if (b <= 8'd5) begin m_fr[0] = b; m_pos = 2; end
            else m_error(2'd2, te);
         2: begin m_fr[1] = b; m_pos = 3; end
         3: begin m_fr[2] = b; m_pos = 4; end
         default: begin
            if (b == (m_fr[0] ^ m_fr[1] ^ m_fr[2])) begin
               m_typ   = m_fr[0][2:0];
               m_data  = {m_fr[1], m_fr[2]};
               m_fcnt  = (m_fcnt + 1) % 65536;
               m_pos   = 0;
               m_issue = te + 1;
               push_ev(1'b1, te);
            end else begin
               m_error(2'd1, te);
            end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer byte b after g idle cycles; the model decides when it is accepted.
   task automatic send(input logic [7:0] b, input int g);
      int te;
      te = cyc + g + 1;
      m_expire(te);
      byte_val = 1'b0;
      repeat (g) tick();
      byte_data = b;
      byte_val  = 1'b1;
      if (te == m_issue) begin
         check("rdy_stall", 32'(byte_rdy), 32'd0);
         tick();
         te++;
      end
      check("rdy", 32'(byte_rdy), 32'd1);
      m_accept(b, te);
      tick();
      byte_val = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] t, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] c, input int g);
      send(8'hA5, g); send(t, g); send(h, g); send(l, g); send(c, g);
   endtask

   task automatic check_reset_vals();
      check("rst_rdy",      32'(byte_rdy),  32'd1);
      check("rst_cmd_type", 32'(cmd_type),  32'd0);
      check("rst_cmd_data", 32'(cmd_data),  32'd0);
      check("rst_cmd_val",  32'(cmd_val),   32'd0);
      check("rst_err",      32'(err_o),     32'd0);
      check("rst_err_code", 32'(err_code),  32'd0);
      check("rst_err_cnt",  32'(err_cnt),   32'd0);
      check("rst_frame_cnt",32'(frame_cnt), 32'd0);
   endtask

   always @(negedge clk) begin
      if (arst_n && (cmd_val || err_o)) begin
         if (expq.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_out: cmd_val=%0b err=%0b code=%0d at cycle %0d, none expected",
                     cmd_val, err_o, err_code, cyc);
         end else begin
            ev_t e;
            e = expq.pop_front();
            check("ev_cmd_val",  32'(cmd_val),   32'(e.is_cmd));
            check("ev_err",      32'(err_o),     32'(!e.is_cmd));
            check("ev_cycle",    32'(cyc),       32'(e.cyc));
            check("ev_cmd_type", 32'(cmd_type),  32'(e.typ));
            check("ev_cmd_data", 32'(cmd_data),  32'(e.data));
            check("ev_err_code", 32'(err_code),  32'(e.code));
            check("ev_err_cnt",  32'(err_cnt),   32'(e.ecnt));
            check("ev_frame_cnt",32'(frame_cnt), 32'(e.fcnt));
         end
      end
   end

   initial begin
      logic [7:0] t, h, l, c;
      int kind, g;
      m_reset();
      #2;
      check_reset_vals();
      repeat (3) @(posedge clk);
      #3 arst_n = 1'b1;
      tick();

      // Directed frames
      send_frame(8'h03, 8'h01, 8'hF4, 8'hF6, 0);
      send_frame(8'h04, 8'h00, 8'h0A, 8'h00, 0);
      send_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
      send_frame(8'h07, 8'h11, 8'h22, 8'h33, 0);
      send_frame(8'h09, 8'hA5, 8'h01, 8'h02, 0);
      send(8'hA5, 0); send(8'h01, 0);
      send(8'hA5, T + 2);
      send(8'h02, 0); send(8'h00, T);
      send_frame(8'h03, 8'hA5, 8'hA5, 8'h03, T - 1);
      send_frame(8'h01, 8'h12, 8'h34, 8'h27, 0);
      send_frame(8'h05, 8'hFF, 8'h00, 8'hFA, 0);

      // Asynchronous reset in the middle of a frame
      send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
      tick();
      #3 arst_n = 1'b0;
      #1;
      m_reset();
      check_reset_vals();
      repeat (2) @(posedge clk);
      #3 arst_n = 1'b1;
      tick();
      send_frame(8'h05, 8'h12, 8'h34, 8'h23, 0);

      // Error counter saturation
      for (int i = 0; i < 260; i++) begin
         send(8'hA5, 0);
         send(8'h07, 0);
      end

      // Randomised traffic
      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 9));
         t = 8'($urandom_range(0, 5));
         h = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
         l = 8'($urandom);
         c = t ^ h ^ l;
         g = int'($urandom_range(0, 19));
         g = (g < 14) ? 0 : (g < 17) ? int'($urandom_range(1, 3)) :
             (g == 17) ? T - 1 : (g == 18) ? T : T + 1;
         if (kind == 6) c = c ^ 8'(1 << $urandom_range(0, 7));
         if (kind == 7) t = 8'($urandom_range(6, 255));
         if (kind == 8) begin
            send(8'($urandom), g);
         end else if (kind == 9) begin
            send(8'hA5, 0); send(t, g);
         end else begin
            send(8'hA5, 0); send(t, 0); send(h, g); send(l, 0); send(c, 0);
         end
      end

      m_expire(cyc + T + 100);
      repeat (T + 10) tick();
      check("queue_empty", 32'(expq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
